// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_pkg
//  Description : Shared constants for the sensor input conditioner.
//                Defines the channel count and the bit position of each
//                sensor in the internal channel vectors, so the ordering
//                lives in exactly one place.
//                The helper count_width returns the counter width needed
//                to hold 0..n-1, with a minimum of 1 bit.
//  Revision    : 1.0  initial release
// ============================================================================
package sensor_pkg;

    localparam int NUM_SENSORS = 6;

    localparam int SNS_LOW   = 0;
    localparam int SNS_MID   = 1;
    localparam int SNS_HIGH  = 2;
    localparam int SNS_EARTH = 3;
    localparam int SNS_AIR   = 4;
    localparam int SNS_TEMP  = 5;

    // Width of a counter that must hold the values 0..n-1.
    // Never returns 0, so a divide-by-1 still gets a legal 1-bit vector.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : sensor_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One sensor channel: a two-flop synchroniser, a
//                disagreement counter and the debounced output register.
//                The output only follows the synchronised input after
//                STABLE_SAMPLES consecutive sample ticks that disagree with
//                the current output. A single agreeing tick clears the count.
//  Ports       : clk     - system clock, rising edge
//                rst_n   - asynchronous active-low reset
//                tick    - sample strobe, one clk cycle wide
//                raw     - unsynchronised sensor input
//                level   - debounced, registered level
//                flipped - high in the cycle whose clock edge flips level
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_channel #(
    parameter int STABLE_SAMPLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic flipped
);

    localparam int                 c_CNT_W    = $clog2(STABLE_SAMPLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_SAMPLES - 1);

    logic               r_sync_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;

    logic w_disagree;
    logic w_qualify;

    assign w_disagree = (r_sync != r_level);
    // The tick that would bring the count to STABLE_SAMPLES flips the
    // output instead, so the counter never reaches STABLE_SAMPLES itself.
    assign w_qualify  = tick & w_disagree & (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_cnt       <= '0;
            r_level     <= 1'b0;
        end else begin
            r_sync_meta <= raw;
            r_sync      <= r_sync_meta;
            if (tick) begin
                if (w_disagree) begin
                    if (w_qualify) begin
                        r_level <= r_sync;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign level   = r_level;
    assign flipped = w_qualify;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_input_conditioner
//  Description : Front end between the raw field sensors and the irrigation
//                logic. Each of the six raw inputs is synchronised and
//                debounced on a slow sample tick produced by a prescaler.
//                A warm-up counter raises a sticky sensor_valid once
//                STABLE_SAMPLES ticks have elapsed since reset, and
//                sensor_changed pulses for one cycle whenever any debounced
//                level flips.
//  Ports       : clk, rst_n (async, active low)
//                raw_*          - six unsynchronised sensor inputs
//                *_level/humidity/temperature - debounced levels
//                sensor_valid   - sticky warm-up complete flag
//                sensor_changed - one-cycle pulse on any level change
//  Revision    : 1.0  initial release
// ============================================================================
module sensor_input_conditioner
    import sensor_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_low_water_level,
    input  logic raw_mid_water_level,
    input  logic raw_high_water_level,
    input  logic raw_earth_humidity,
    input  logic raw_air_humidity,
    input  logic raw_low_temperature,
    output logic low_water_level,
    output logic mid_water_level,
    output logic high_water_level,
    output logic earth_humidity,
    output logic air_humidity,
    output logic low_temperature,
    output logic sensor_valid,
    output logic sensor_changed
);

    localparam int                  c_DIV_W     = count_width(CLK_DIV);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam int                  c_WARM_W    = $clog2(STABLE_SAMPLES + 1);
    localparam logic [c_WARM_W-1:0] c_WARM_DONE = c_WARM_W'(STABLE_SAMPLES);
    localparam logic [c_WARM_W-1:0] c_WARM_LAST = c_WARM_W'(STABLE_SAMPLES - 1);

    logic [c_DIV_W-1:0]     r_prescale;
    logic [c_WARM_W-1:0]    r_warm;
    logic                   r_valid;
    logic                   r_changed;

    logic                   w_tick;
    logic [NUM_SENSORS-1:0] w_raw;
    logic [NUM_SENSORS-1:0] w_level;
    logic [NUM_SENSORS-1:0] w_flipped;

    assign w_tick = (r_prescale == c_DIV_LAST);

    // Prescaler: counts 0..CLK_DIV-1 so the first tick lands CLK_DIV
    // cycles after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Warm-up: saturating tick counter; valid is set by the same edge that
    // registers the STABLE_SAMPLES-th tick and then holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm  <= '0;
            r_valid <= 1'b0;
        end else if (w_tick) begin
            if (r_warm != c_WARM_DONE) begin
                r_warm <= r_warm + 1'b1;
            end
            if (r_warm == c_WARM_LAST) begin
                r_valid <= 1'b1;
            end
        end
    end

    // Registered on the same edge as the channel flips, so the pulse is
    // visible exactly in the first cycle the new levels are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_flipped;
        end
    end

    assign w_raw[SNS_LOW]   = raw_low_water_level;
    assign w_raw[SNS_MID]   = raw_mid_water_level;
    assign w_raw[SNS_HIGH]  = raw_high_water_level;
    assign w_raw[SNS_EARTH] = raw_earth_humidity;
    assign w_raw[SNS_AIR]   = raw_air_humidity;
    assign w_raw[SNS_TEMP]  = raw_low_temperature;

    generate
        for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_channel
            debounce_channel #(
                .STABLE_SAMPLES (STABLE_SAMPLES)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .tick    (w_tick),
                .raw     (w_raw[gi]),
                .level   (w_level[gi]),
                .flipped (w_flipped[gi])
            );
        end
    endgenerate

    assign low_water_level  = w_level[SNS_LOW];
    assign mid_water_level  = w_level[SNS_MID];
    assign high_water_level = w_level[SNS_HIGH];
    assign earth_humidity   = w_level[SNS_EARTH];
    assign air_humidity     = w_level[SNS_AIR];
    assign low_temperature  = w_level[SNS_TEMP];
    assign sensor_valid     = r_valid;
    assign sensor_changed   = r_changed;

endmodule : sensor_input_conditioner
`default_nettype wire

// File: tb/tb_sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_input_conditioner
//  Description : Self-checking bench. Two instances run side by side:
//                dut_slow (CLK_DIV=4, STABLE_SAMPLES=3) and
//                dut_fast (CLK_DIV=1, STABLE_SAMPLES=1). A reference model
//                derives expected levels from the raw history: the filter
//                sees the raw value of two edges ago, ticks fall on edges
//                where (edge index mod CLK_DIV) == CLK_DIV-1, and an output
//                flips after STABLE_SAMPLES consecutive disagreeing ticks.
//                Bit order in bench vectors: 0 low, 1 mid, 2 high,
//                3 earth, 4 air, 5 temperature.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sensor_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] raw [2];
    logic [5:0] lvl [2];
    logic       vld [2];
    logic       chg [2];

    int checks = 0;
    int fails  = 0;

    // reference model state, index 0 = slow instance, 1 = fast instance
    int         m_div  [2] = '{4, 1};
    int         m_stab [2] = '{3, 1};
    int         m_edge [2];
    int         m_ticks[2];
    int         m_run  [2][6];
    logic [5:0] m_out  [2];
    logic       m_chg  [2];
    logic [5:0] m_log  [2][4096];

    always #5 clk = ~clk;

    sensor_input_conditioner #(.CLK_DIV(4), .STABLE_SAMPLES(3)) dut_slow (
        .clk                  (clk),
        .rst_n                (rst_n),
        .raw_low_water_level  (raw[0][0]),
        .raw_mid_water_level  (raw[0][1]),
        .raw_high_water_level (raw[0][2]),
        .raw_earth_humidity   (raw[0][3]),
        .raw_air_humidity     (raw[0][4]),
        .raw_low_temperature  (raw[0][5]),
        .low_water_level      (lvl[0][0]),
        .mid_water_level      (lvl[0][1]),
        .high_water_level     (lvl[0][2]),
        .earth_humidity       (lvl[0][3]),
        .air_humidity         (lvl[0][4]),
        .low_temperature      (lvl[0][5]),
        .sensor_valid         (vld[0]),
        .sensor_changed       (chg[0])
    );

    sensor_input_conditioner #(.CLK_DIV(1), .STABLE_SAMPLES(1)) dut_fast (
        .clk                  (clk),
        .rst_n                (rst_n),
        .raw_low_water_level  (raw[1][0]),
        .raw_mid_water_level  (raw[1][1]),
        .raw_high_water_level (raw[1][2]),
        .raw_earth_humidity   (raw[1][3]),
        .raw_air_humidity     (raw[1][4]),
        .raw_low_temperature  (raw[1][5]),
        .low_water_level      (lvl[1][0]),
        .mid_water_level      (lvl[1][1]),
        .high_water_level     (lvl[1][2]),
        .earth_humidity       (lvl[1][3]),
        .air_humidity         (lvl[1][4]),
        .low_temperature      (lvl[1][5]),
        .sensor_valid         (vld[1]),
        .sensor_changed       (chg[1])
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_edge[d]  = 0;
            m_ticks[d] = 0;
            m_out[d]   = '0;
            m_chg[d]   = 1'b0;
            for (int c = 0; c < 6; c++) m_run[d][c] = 0;
        end
    endtask

    // Advance the model by one clock edge with the raw values present at it.
    task automatic model_edge(input int d);
        logic [5:0] seen;
        int         k;
        k    = m_edge[d];
        seen = (k >= 2) ? m_log[d][k-2] : 6'd0;
        m_log[d][k] = raw[d];
        m_chg[d] = 1'b0;
        if ((k % m_div[d]) == m_div[d] - 1) begin
            m_ticks[d]++;
            for (int c = 0; c < 6; c++) begin
                if (seen[c] != m_out[d][c]) begin
                    m_run[d][c]++;
                    if (m_run[d][c] == m_stab[d]) begin
                        m_out[d][c] = seen[c];
                        m_run[d][c] = 0;
                        m_chg[d]    = 1'b1;
                    end
                end else begin
                    m_run[d][c] = 0;
                end
            end
        end
        m_edge[d] = k + 1;
    endtask

    // One clock cycle: apply raw inputs, take the edge, compare both DUTs.
    task automatic cycle(input logic [5:0] r0, input logic [5:0] r1);
        raw[0] = r0;
        raw[1] = r1;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("slow", {lvl[0], vld[0], chg[0]},
              {m_out[0], (m_ticks[0] >= m_stab[0]), m_chg[0]});
        check("fast", {lvl[1], vld[1], chg[1]},
              {m_out[1], (m_ticks[1] >= m_stab[1]), m_chg[1]});
    endtask

    // Asynchronous assert away from the edge, check, then release mid-cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_slow", {lvl[0], vld[0], chg[0]}, 8'd0);
        check("rst_fast", {lvl[1], vld[1], chg[1]}, 8'd0);
        raw[0] = '0;
        raw[1] = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] r0;
        logic [5:0] r1;
        raw[0] = '0;
        raw[1] = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1: all quiet; valid rises on the edge registering the third tick
        for (int c = 0; c < 16; c++) begin
            cycle(6'd0, 6'd0);
            if (c == 10) check("t1_valid_before", {7'd0, vld[0]}, 8'd0);
            if (c == 11) check("t1_valid_rise",   {7'd0, vld[0]}, 8'd1);
        end

        // 2: low float rises at cycle 0 and qualifies on the tick at edge 11
        do_reset();
        for (int c = 0; c < 16; c++) begin
            cycle(6'b000001, 6'd0);
            if (c == 10) check("t2_low_before", {lvl[0], 2'b00}, 8'd0);
            if (c == 11) check("t2_low_rise", {lvl[0], 1'b0, chg[0]}, 8'b00000101);
            if (c == 12) check("t2_chg_drop", {7'd0, chg[0]}, 8'd0);
        end

        // 3: six-cycle glitch on the high float never reaches the output
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cycle((c < 6) ? 6'b000100 : 6'd0, 6'd0);
        end
        check("t3_high_quiet", {7'd0, lvl[0][2]}, 8'd0);

        // 4: earth and air rise together -> one shared flip and pulse
        do_reset();
        for (int c = 0; c < 16; c++) begin
            cycle(6'b011000, 6'd0);
            if (c == 11) check("t4_pair_flip", {lvl[0], 1'b0, chg[0]}, 8'b01100001);
        end

        // 5: mid float rises, reset strikes mid-qualification
        do_reset();
        for (int c = 0; c < 10; c++) cycle(6'b000010, 6'd0);
        do_reset();
        for (int c = 0; c < 14; c++) begin
            cycle(6'b000010, 6'd0);
            if (c == 10) check("t5_mid_before", {7'd0, lvl[0][1]}, 8'd0);
            if (c == 11) check("t5_mid_rise",   {7'd0, lvl[0][1]}, 8'd1);
        end

        // 6: fast instance, temperature toggles -> three-cycle follow
        do_reset();
        for (int c = 0; c < 24; c++) begin
            cycle(6'd0, ((c / 3) % 2 == 1) ? 6'b100000 : 6'd0);
        end

        // randomized phases on both instances with occasional resets
        r0 = '0;
        r1 = '0;
        for (int p = 0; p < 4; p++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                for (int b = 0; b < 6; b++) begin
                    if ($urandom_range(0, 11) == 0) r0[b] = ~r0[b];
                    if ($urandom_range(0, 3) == 0)  r1[b] = ~r1[b];
                end
                cycle(r0, r1);
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule : tb_sensor_input_conditioner
`default_nettype wire
